// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   dw_t        : access width of a load/store (byte, half, word)
//   WORD_BYTES  : bytes per memory word
//   misaligned(): true when an access of the given width cannot start at
//                 the given byte offset within a word
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    DB = 2'd0,
    DH = 2'd1,
    DW = 2'd2
  } dw_t;

  localparam int WORD_BYTES = 4;

  function automatic logic misaligned(input dw_t dw, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (dw)
      DH:      bad = a[0];
      DW:      bad = (a != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering between the core and a 32-bit memory word.
// Ports:
//   st_dw_i, st_a_i, st_wdata_i : store width, byte offset, right-justified data
//   st_be_o, st_wdata_o         : byte enables and lane-replicated store word
//   ld_dw_i, ld_sign_i, ld_a_i  : load width, sign-extend flag, byte offset
//   ld_rdata_i                  : raw memory word
//   ld_data_o                   : aligned and extended load value
module dmem_lane_align
  import dmem_arbiter_pkg::*;
(
  input  dw_t         st_dw_i,
  input  logic [1:0]  st_a_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  dw_t         ld_dw_i,
  input  logic        ld_sign_i,
  input  logic [1:0]  ld_a_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
    return {{24{sgn & v[7]}}, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    return {{16{sgn & v[15]}}, v};
  endfunction

  logic [31:0] lane;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_wdata_i;
    case (st_dw_i)
      DB: begin
        st_be_o    = 4'b0001 << st_a_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      DH: begin
        st_be_o    = 4'b0011 << st_a_i;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
      end
    endcase
  end

  // The addressed byte/half is shifted down to bit 0 before extension.
  assign lane = ld_rdata_i >> {ld_a_i, 3'b000};

  always_comb begin
    ld_data_o = lane;
    case (ld_dw_i)
      DB:      ld_data_o = ext8(lane[7:0], ld_sign_i);
      DH:      ld_data_o = ext16(lane[15:0], ld_sign_i);
      default: ld_data_o = lane;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data memory between instruction fetch
// (word reads only) and load/store. LS wins by default; IF is forced through
// after STARVE_MAX consecutive losses. Misaligned LS accesses are rejected
// with a one-cycle ls_err pulse and never touch memory.
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   if_req/if_addr/if_gnt            : IF request handshake
//   if_rvalid/if_rdata               : IF read response (one cycle after grant)
//   ls_req/ls_we/ls_dw/ls_sign/
//   ls_addr/ls_wdata/ls_gnt          : LS request handshake
//   ls_rvalid/ls_rdata/ls_err        : LS completion / rejection
//   mem_en/mem_we/mem_be/mem_addr/
//   mem_wdata/mem_rdata              : memory port
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  dw_t               ls_dw,
  input  logic              ls_sign,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              ls_mis, if_forced, ls_wins;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        st_be;
  logic [31:0]       ld_data;

  // Response pipe: control fields reset, payload fields free-running.
  logic              rsp_vld_q, err_q;
  logic              rsp_ls_q, rsp_load_q, rsp_sign_q;
  dw_t               rsp_dw_q;
  logic [1:0]        rsp_a_q;

  assign ls_mis    = misaligned(ls_dw, ls_addr[1:0]);
  assign if_forced = if_req && (starve_cnt_q == STARVE_LIM);
  assign ls_wins   = ls_req && !if_forced;
  assign ls_gnt    = ls_wins && !ls_mis;
  // IF also takes the port when LS wins arbitration but is rejected.
  assign if_gnt    = if_req && !ls_gnt;

  assign mem_en    = if_gnt || ls_gnt;
  assign mem_we    = ls_gnt && ls_we;
  assign mem_be    = ls_gnt ? st_be : 4'b1111;
  assign sel_addr  = ls_gnt ? ls_addr : if_addr;
  assign mem_addr  = sel_addr & ~ADDR_W'(3);

  always_comb begin
    starve_cnt_d = 4'd0;
    if (if_req && !if_gnt)
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
  end

  dmem_lane_align u_align (
    .st_dw_i    (ls_dw),
    .st_a_i     (ls_addr[1:0]),
    .st_wdata_i (ls_wdata),
    .st_be_o    (st_be),
    .st_wdata_o (mem_wdata),
    .ld_dw_i    (rsp_dw_q),
    .ld_sign_i  (rsp_sign_q),
    .ld_a_i     (rsp_a_q),
    .ld_rdata_i (mem_rdata),
    .ld_data_o  (ld_data)
  );

  // ---- grant cycle -> response cycle ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
      rsp_vld_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_vld_q    <= mem_en;
      err_q        <= ls_wins && ls_mis;
    end
  end

  always_ff @(posedge clk) begin
    rsp_ls_q   <= ls_gnt;
    rsp_load_q <= !ls_we;
    rsp_dw_q   <= ls_dw;
    rsp_sign_q <= ls_sign;
    rsp_a_q    <= ls_addr[1:0];
  end

  // A reset asserted while a response is in flight squashes it immediately.
  assign if_rvalid = rst_n && rsp_vld_q && !rsp_ls_q;
  assign if_rdata  = mem_rdata;
  assign ls_rvalid = rst_n && rsp_vld_q && rsp_ls_q;
  assign ls_rdata  = rsp_load_q ? ld_data : 32'd0;
  assign ls_err    = rst_n && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we, ls_sign;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  dw_t         ls_dw;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err;
  logic [31:0] if_rdata, ls_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  dmem_arbiter #(.ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_dw(ls_dw), .ls_sign(ls_sign),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory model; word 1 preloaded for IF reads.
  logic [31:0] mem [0:15];
  bit          init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 1) ? 32'hDEADBEEF : 32'h0;
      init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[5:2]];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t if_q[$];
  exp_t ls_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_if(input logic [31:0] d);
    exp_t e;
    e.due = cyc + 1; e.err = 1'b0; e.data = d;
    if_q.push_back(e);
  endtask

  task automatic push_ls(input logic err, input logic [31:0] d);
    exp_t e;
    e.due = cyc + 1; e.err = err; e.data = d;
    ls_q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (if_rvalid) begin
      if (if_q.size() == 0) begin
        check("if_unexpected_rvalid", 32'(if_rvalid), 32'd0);
      end else begin
        e = if_q.pop_front();
        check("if_latency", 32'(cyc), 32'(e.due));
        check("if_rdata", if_rdata, e.data);
      end
    end
    if (ls_rvalid || ls_err) begin
      if (ls_q.size() == 0) begin
        check("ls_unexpected_resp", {30'd0, ls_rvalid, ls_err}, 32'd0);
      end else begin
        e = ls_q.pop_front();
        check("ls_latency", 32'(cyc), 32'(e.due));
        check("ls_err", 32'(ls_err), 32'(e.err));
        check("ls_rvalid", 32'(ls_rvalid), 32'(!e.err));
        if (!e.err) check("ls_rdata", ls_rdata, e.data);
      end
    end
    if (if_gnt && ls_gnt) check("gnt_exclusive", 32'(if_gnt && ls_gnt), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ls_op(input logic we, input dw_t dw, input logic sg, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] erd);
    ls_req = 1'b1; ls_we = we; ls_dw = dw; ls_sign = sg; ls_addr = addr; ls_wdata = wd;
    if_req = 1'b0;
    @(negedge clk);
    check("ls_gnt", 32'(ls_gnt), 32'd1);
    check("mem_en", 32'(mem_en), 32'd1);
    check("mem_we", 32'(mem_we), 32'(we));
    check("mem_be", 32'(mem_be), 32'(ebe));
    check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
    if (we) check("mem_wdata", mem_wdata, ewd);
    push_ls(1'b0, we ? 32'd0 : erd);
    tick();
    ls_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h4;
    ls_req = 1'b1; ls_we = 1'b0; ls_dw = DW; ls_sign = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;

    // Reset with both requests high: no responses may come out.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      check("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
      check("rst_ls_err", 32'(ls_err), 32'd0);
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("post_rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check("post_rst_ls_gnt", 32'(ls_gnt), 32'd1);
    check("post_rst_if_gnt", 32'(if_gnt), 32'd0);
    push_ls(1'b0, 32'h0);
    tick();
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // Byte store then byte loads with sign / zero extension.
    ls_op(1'b1, DB, 1'b0, 32'h2, 32'h0000_00F4, 4'b0100, 32'hF4F4_F4F4, 32'h0);
    ls_op(1'b0, DB, 1'b1, 32'h2, 32'h0, 4'b0100, 32'h0, 32'hFFFF_FFF4);
    ls_op(1'b0, DB, 1'b0, 32'h2, 32'h0, 4'b0100, 32'h0, 32'h0000_00F4);

    // Word store then half loads from both halves.
    ls_op(1'b1, DW, 1'b0, 32'h0, 32'h0102_F3F4, 4'b1111, 32'h0102_F3F4, 32'h0);
    ls_op(1'b0, DH, 1'b1, 32'h2, 32'h0, 4'b1100, 32'h0, 32'h0000_0102);
    ls_op(1'b0, DH, 1'b1, 32'h0, 32'h0, 4'b0011, 32'h0, 32'hFFFF_F3F4);
    ls_op(1'b0, DB, 1'b1, 32'h1, 32'h0, 4'b0010, 32'h0, 32'hFFFF_FFF3);

    // Misaligned half with concurrent IF: IF takes the port.
    ls_req = 1'b1; ls_we = 1'b0; ls_dw = DH; ls_addr = 32'h1;
    if_req = 1'b1; if_addr = 32'h5;
    @(negedge clk);
    check("mis_dh_ls_gnt", 32'(ls_gnt), 32'd0);
    check("mis_dh_if_gnt", 32'(if_gnt), 32'd1);
    check("mis_dh_mem_en", 32'(mem_en), 32'd1);
    check("mis_dh_mem_we", 32'(mem_we), 32'd0);
    check("mis_dh_mem_addr", mem_addr, 32'h4);
    push_if(32'hDEAD_BEEF);
    push_ls(1'b1, 32'h0);
    tick();
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // Misaligned word alone: no memory access at all.
    ls_req = 1'b1; ls_we = 1'b1; ls_dw = DW; ls_addr = 32'h2; ls_wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    check("mis_dw_ls_gnt", 32'(ls_gnt), 32'd0);
    check("mis_dw_mem_en", 32'(mem_en), 32'd0);
    push_ls(1'b1, 32'h0);
    tick();
    ls_req = 1'b0;
    tick();

    // Starvation: both requests held; IF must win every fifth cycle.
    ls_req = 1'b1; ls_we = 1'b0; ls_dw = DW; ls_sign = 1'b0; ls_addr = 32'h0;
    if_req = 1'b1; if_addr = 32'h4;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("starve_if_gnt", 32'(if_gnt), 32'((i % 5) == 4));
      check("starve_ls_gnt", 32'(ls_gnt), 32'((i % 5) != 4));
      if ((i % 5) == 4) push_if(32'hDEAD_BEEF);
      else push_ls(1'b0, 32'h0102_F3F4);
      tick();
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // Reset arriving the cycle after a load grant kills its response.
    ls_req = 1'b1; ls_we = 1'b0; ls_dw = DW; ls_addr = 32'h0;
    @(negedge clk);
    check("midrst_ls_gnt", 32'(ls_gnt), 32'd1);
    tick();
    ls_req = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check("midrst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    tick();
    rst_n = 1'b1;
    ls_op(1'b0, DH, 1'b0, 32'h0, 32'h0, 4'b0011, 32'h0, 32'h0000_F3F4);
    tick();
    tick();

    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    check("ls_queue_drained", 32'(ls_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
